// File: rtl/jtag_debug_host_pkg.sv
// Shared types and constants for the on-chip virtual-JTAG debug host.
package jtag_debug_host_pkg;

  typedef enum logic [2:0] {
    IDLE,
    UIR,
    CDR,
    SDR,
    UDR,
    RTI,
    DONE
  } state_e;

  localparam logic [1:0] IR_OCIMEM    = 2'd0;
  localparam logic [1:0] IR_TRACEMEM  = 2'd1;
  localparam logic [1:0] IR_BREAK     = 2'd2;
  localparam logic [1:0] IR_TRACECTRL = 2'd3;

  localparam int DEFAULT_SR_WIDTH = 38;

endpackage

// File: rtl/jtag_debug_host_tck_gen.sv
// TCK divider: low for TCK_DIV clk cycles, then high for TCK_DIV cycles, while enabled.
module jtag_debug_host_tck_gen #(
  parameter int TCK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic tck,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic period_end
);

  localparam int CW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

  logic [CW-1:0] div_cnt;
  logic          half_end;

  assign half_end = en && (div_cnt == CW'(TCK_DIV - 1));

  // tck doubles as the half-period bit, so the output is registered and
  // parks low whenever the generator is disabled
  always_ff @(posedge clk) begin
    if (!reset_n || !en) begin
      div_cnt <= '0;
      tck     <= 1'b0;
    end else if (half_end) begin
      div_cnt <= '0;
      tck     <= ~tck;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

  assign rise_pulse = half_end && !tck;
  assign fall_pulse = half_end && tck;
  assign period_end = fall_pulse;

endmodule

// File: rtl/jtag_debug_host_sequencer.sv
// Drives one UIR/CDR/SDR/UDR/RTI virtual-JTAG scan per command and returns
// the SR_WIDTH bits captured from TDO.
module jtag_debug_host_sequencer
  import jtag_debug_host_pkg::*;
#(
  parameter int SR_WIDTH = DEFAULT_SR_WIDTH,
  parameter int TCK_DIV  = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_ir,
  input  logic [SR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [SR_WIDTH-1:0] rsp_data,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [1:0]          vji_ir_in,
  input  logic [1:0]          vji_ir_out,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);

  if (TCK_DIV < 2) begin : g_tck_div_check
    $error("jtag_debug_host_sequencer: TCK_DIV must be at least 2");
  end

  localparam int BW = (SR_WIDTH > 1) ? $clog2(SR_WIDTH) : 1;

  state_e              state, state_nxt;
  logic [SR_WIDTH-1:0] tx, rx;
  logic [BW-1:0]       bit_cnt;
  logic                scan_en, tck_rise, period_end, last_bit, accept;
  logic                tck_fall_unused, ir_out_unused;

  // IR-out is reserved by the debug module and carries nothing we act on
  assign ir_out_unused = ^vji_ir_out;

  assign scan_en  = state inside {UIR, CDR, SDR, UDR, RTI};
  assign last_bit = (bit_cnt == BW'(SR_WIDTH - 1));
  assign accept   = cmd_valid && cmd_ready;

  jtag_debug_host_tck_gen #(
    .TCK_DIV(TCK_DIV)
  ) u_tck_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (scan_en),
    .tck       (vji_tck),
    .rise_pulse(tck_rise),
    .fall_pulse(tck_fall_unused),
    .period_end(period_end)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    vji_uir   = 1'b0;
    vji_cdr   = 1'b0;
    vji_sdr   = 1'b0;
    vji_udr   = 1'b0;
    vji_rti   = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = UIR;
      end
      UIR: begin
        vji_uir = 1'b1;
        if (period_end) state_nxt = CDR;
      end
      CDR: begin
        vji_cdr = 1'b1;
        if (period_end) state_nxt = SDR;
      end
      SDR: begin
        vji_sdr = 1'b1;
        if (period_end && last_bit) state_nxt = UDR;
      end
      UDR: begin
        vji_udr = 1'b1;
        if (period_end) state_nxt = RTI;
      end
      RTI: begin
        vji_rti = 1'b1;
        if (period_end) state_nxt = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        rsp_data  = rx;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // TDI moves on the TCK falling edge that opens each SDR period; the first
  // bit is loaded as CDR closes so it is stable for the whole first period
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx        <= '0;
      rx        <= '0;
      bit_cnt   <= '0;
      vji_tdi   <= 1'b0;
      vji_ir_in <= '0;
    end else begin
      if (accept) begin
        vji_ir_in <= cmd_ir;
        tx        <= cmd_data;
        bit_cnt   <= '0;
      end
      if (period_end && (state == CDR || (state == SDR && !last_bit))) begin
        vji_tdi <= tx[0];
        tx      <= tx >> 1;
      end else if (period_end && state == SDR) begin
        vji_tdi <= 1'b0;
      end
      if (period_end && state == SDR) bit_cnt <= bit_cnt + BW'(1);
      if (tck_rise && state == SDR) rx <= {vji_tdo, rx[SR_WIDTH-1:1]};
      if (state == DONE && rsp_ready) vji_ir_in <= '0;
    end
  end

endmodule

// File: tb/tb_jtag_debug_host_sequencer.sv
// Bench for jtag_debug_host_sequencer: a cycle-position model of the scan
// timeline checked every cycle, plus directed scans with literal expectations.
module tb_jtag_debug_host_sequencer;

  localparam int W    = 38;
  localparam int D    = 4;
  localparam int W2   = 8;
  localparam int D2   = 2;
  localparam int SCAN = (W + 4) * 2 * D;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic          cmd_valid, cmd_ready, rsp_valid, rsp_ready;
  logic [1:0]    cmd_ir, vji_ir_in, vji_ir_out;
  logic [W-1:0]  cmd_data, rsp_data;
  logic          vji_tck, vji_tdi, vji_tdo;
  logic          vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

  logic          cmd_valid2, cmd_ready2, rsp_valid2, rsp_ready2;
  logic [1:0]    cmd_ir2, vji_ir_in2, vji_ir_out2;
  logic [W2-1:0] cmd_data2, rsp_data2;
  logic          vji_tck2, vji_tdi2, vji_tdo2;
  logic          vji_uir2, vji_cdr2, vji_sdr2, vji_udr2, vji_rti2;

  jtag_debug_host_sequencer #(.SR_WIDTH(W), .TCK_DIV(D)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo),
    .vji_ir_in(vji_ir_in), .vji_ir_out(vji_ir_out),
    .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr), .vji_rti(vji_rti)
  );

  jtag_debug_host_sequencer #(.SR_WIDTH(W2), .TCK_DIV(D2)) dut2 (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2), .cmd_ir(cmd_ir2), .cmd_data(cmd_data2),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_data(rsp_data2),
    .vji_tck(vji_tck2), .vji_tdi(vji_tdi2), .vji_tdo(vji_tdo2),
    .vji_ir_in(vji_ir_in2), .vji_ir_out(vji_ir_out2),
    .vji_uir(vji_uir2), .vji_cdr(vji_cdr2), .vji_sdr(vji_sdr2), .vji_udr(vji_udr2), .vji_rti(vji_rti2)
  );

  assign vji_ir_out  = 2'b00;
  assign vji_ir_out2 = 2'b00;
  assign vji_tdo2    = vji_tdi2;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Model: position of the current cycle within the scan, counted from accept
  int           cyc_n = 0;
  bit           seen_rst = 1'b0;
  bit           m_busy = 1'b0;
  int           m_t = 0;
  int           m_acc = 0;
  logic [1:0]   m_ir;
  logic [W-1:0] m_data, m_tdo, tdo_pat;

  always @(posedge clk) begin
    if (!reset_n) begin
      seen_rst = 1'b1;
      m_busy   = 1'b0;
    end else if (m_busy) begin
      if (m_t > SCAN) begin
        if (rsp_ready) m_busy = 1'b0;
      end else begin
        m_t++;
      end
    end else if (cmd_valid) begin
      m_busy = 1'b1;
      m_t    = 1;
      m_acc  = cyc_n;
      m_ir   = cmd_ir;
      m_data = cmd_data;
      m_tdo  = tdo_pat;
    end
    cyc_n++;
  end

  // TDO source: bit k of the pattern during the k-th SDR period
  always @(negedge clk) begin : tdo_drv
    int p;
    vji_tdo = 1'b0;
    if (m_busy) begin
      p = (m_t - 1) / (2 * D);
      if (p >= 2 && p < W + 2) vji_tdo = m_tdo[p - 2];
    end
  end

  int           rises = 0, sdr_rises = 0;
  logic [W-1:0] tdi_seq = '0;
  logic         prev_tck = 1'b0;

  always @(negedge clk) begin : compare
    int p, ph;
    bit done;
    logic [4:0] exp_flags;
    if (vji_tck && !prev_tck) begin
      rises++;
      if (vji_sdr) begin
        sdr_rises++;
        tdi_seq = {vji_tdi, tdi_seq[W-1:1]};
      end
    end
    prev_tck = vji_tck;
    if (seen_rst) begin
      if (!m_busy) begin
        check("idle cmd_ready", cmd_ready, 1);
        check("idle rsp_valid", rsp_valid, 0);
        check("idle tck", vji_tck, 0);
        check("idle tdi", vji_tdi, 0);
        check("idle ir_in", vji_ir_in, 0);
        check("idle flags", {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}, 0);
      end else begin
        p    = (m_t - 1) / (2 * D);
        ph   = (m_t - 1) % (2 * D);
        done = (p >= W + 4);
        if (p == 0)          exp_flags = 5'b10000;
        else if (p == 1)     exp_flags = 5'b01000;
        else if (p < W + 2)  exp_flags = 5'b00100;
        else if (p == W + 2) exp_flags = 5'b00010;
        else if (p == W + 3) exp_flags = 5'b00001;
        else                 exp_flags = 5'b00000;
        check("busy cmd_ready", cmd_ready, 0);
        check("rsp_valid", rsp_valid, done);
        check("flags", {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}, exp_flags);
        check("tck", vji_tck, !done && ph >= D);
        check("tdi", vji_tdi, (p >= 2 && p < W + 2) ? m_data[p - 2] : 1'b0);
        if (!done) check("ir_in", vji_ir_in, m_ir);
        if (done)  check("rsp_data", rsp_data, m_tdo);
      end
    end
  end

  // Second instance: half-period widths and rising-edge count
  int   rises2 = 0, last_rise2 = 0, last_fall2 = -1;
  logic prev_tck2 = 1'b0;

  always @(negedge clk) begin : mon2
    if (vji_tck2 && !prev_tck2) begin
      rises2++;
      if (last_fall2 >= 0) check("tck2 low len", cyc_n - last_fall2, D2);
      last_rise2 = cyc_n;
    end
    if (!vji_tck2 && prev_tck2) begin
      check("tck2 high len", cyc_n - last_rise2, D2);
      last_fall2 = cyc_n;
    end
    prev_tck2 = vji_tck2;
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] ir, input logic [W-1:0] data, input logic [W-1:0] pat);
    cmd_ir    = ir;
    cmd_data  = data;
    tdo_pat   = pat;
    rises     = 0;
    sdr_rises = 0;
    tdi_seq   = '0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (cmd_ready) break;
      cyc();
    end
    check("cmd accepted", cmd_ready, 1);
    cyc();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 1000; i++) begin
      if (rsp_valid) break;
      cyc();
    end
    check("rsp_valid arrives", rsp_valid, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    cmd_valid  = 1'b0;
    cmd_ir     = 2'd0;
    cmd_data   = '0;
    rsp_ready  = 1'b1;
    tdo_pat    = '0;
    cmd_valid2 = 1'b0;
    cmd_ir2    = 2'd0;
    cmd_data2  = '0;
    rsp_ready2 = 1'b1;

    // 1. reset values
    cyc(3);
    check("rst cmd_ready", cmd_ready, 1);
    check("rst rsp_valid", rsp_valid, 0);
    check("rst rsp_data", rsp_data, 0);
    check("rst tck", vji_tck, 0);
    check("rst tdi", vji_tdi, 0);
    check("rst ir_in", vji_ir_in, 0);
    check("rst flags", {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}, 0);
    check("rst tck rises", rises, 0);
    reset_n = 1'b1;
    cyc(2);

    // 2. single scan
    send(2'd2, 38'h2A_AAAA_AAAA, 38'h15_5555_5555);
    wait_rsp();
    check("scan rsp_data", rsp_data, 38'h15_5555_5555);
    check("scan latency", cyc_n - m_acc, 337);
    check("scan tdi seq", tdi_seq, 38'h2A_AAAA_AAAA);
    check("scan tck rises", rises, 42);
    check("scan sdr rises", sdr_rises, 38);
    cyc();
    check("scan cmd_ready after", cmd_ready, 1);

    // 3. response backpressure
    rsp_ready = 1'b0;
    send(2'd1, 38'h03_0F0F_1234, 38'h2A_5A5A_0001);
    wait_rsp();
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("bp rsp_valid", rsp_valid, 1);
      check("bp rsp_data", rsp_data, 38'h2A_5A5A_0001);
      check("bp cmd_ready", cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    cyc();
    check("bp cmd_ready after", cmd_ready, 1);
    check("bp rsp_valid after", rsp_valid, 0);

    // 4. command while busy is ignored
    send(2'd0, 38'h01_2345_6789, 38'h3F_0000_FFFF);
    cyc(40);
    cmd_ir    = 2'd3;
    cmd_data  = 38'h00_0000_0000;
    cmd_valid = 1'b1;
    cyc(3);
    cmd_valid = 1'b0;
    wait_rsp();
    check("busy rsp_data", rsp_data, 38'h3F_0000_FFFF);
    check("busy tdi seq", tdi_seq, 38'h01_2345_6789);
    cyc();

    // 5. reset after 10 SDR shifts
    send(2'd3, 38'h25_AAAA_5555, 38'h0A_1234_5678);
    cyc(96);
    check("abort sdr rises", sdr_rises, 10);
    check("abort in sdr", vji_sdr, 1);
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    check("abort cmd_ready", cmd_ready, 1);
    check("abort rsp_valid", rsp_valid, 0);
    check("abort rsp_data", rsp_data, 0);
    check("abort tck", vji_tck, 0);
    check("abort tdi", vji_tdi, 0);
    check("abort ir_in", vji_ir_in, 0);
    check("abort flags", {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}, 0);
    cyc(20);
    send(2'd1, 38'h00_0000_00FF, 38'h3F_FFFF_FFFF);
    wait_rsp();
    check("post-abort rsp_data", rsp_data, 38'h3F_FFFF_FFFF);
    check("post-abort latency", cyc_n - m_acc, 337);
    cyc();

    // 6. short register, fastest TCK, loopback
    begin : t6
      int acc2;
      acc2       = 0;
      rises2     = 0;
      cmd_ir2    = 2'd1;
      cmd_data2  = 8'hA5;
      cmd_valid2 = 1'b1;
      for (int i = 0; i < 100; i++) begin
        if (cmd_ready2) break;
        cyc();
      end
      check("small accepted", cmd_ready2, 1);
      acc2 = cyc_n;
      cyc();
      cmd_valid2 = 1'b0;
      for (int i = 0; i < 200; i++) begin
        if (rsp_valid2) break;
        cyc();
      end
      check("small rsp_valid", rsp_valid2, 1);
      check("small latency", cyc_n - acc2, 49);
      check("small rsp_data", rsp_data2, 8'hA5);
      check("small tck rises", rises2, 12);
      cyc();
      check("small cmd_ready after", cmd_ready2, 1);
    end

    cyc(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
